// File: rtl/quad_paddle_decoder.sv
// Quadrature paddle decoder: 2-flop synchronizers, optional glitch filter, saturating position
// and per-frame step delta. Define QUAD_PADDLE_FILTER_EN to compile in the per-channel filter.
module quad_paddle_decoder #(
    parameter int unsigned POS_WIDTH  = 9,
    parameter int unsigned POS_MAX    = 511,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 quadA,
    input  logic                 quadB,
    input  logic                 frame_latch,
    output logic [POS_WIDTH-1:0] position,
    output logic [POS_WIDTH-1:0] position_frame,
    output logic [7:0]           delta_frame,
    output logic                 step,
    output logic                 dir,
    output logic                 quad_err
);

    localparam logic [POS_WIDTH-1:0] PosMax = POS_WIDTH'(POS_MAX);
    localparam logic [7:0] AccMax = 8'h7F;
    localparam logic [7:0] AccMin = 8'h80;

    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : gen_bad_filter_len
        $error("FILTER_LEN must be in 2..15");
    end
    if (POS_MAX > 2 ** POS_WIDTH - 1) begin : gen_bad_pos_max
        $error("POS_MAX does not fit in POS_WIDTH bits");
    end

    // Channel pairs are packed as {A, B}.
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] cond;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {quadA, quadB};
            sync2_q <= sync1_q;
        end
    end

`ifdef QUAD_PADDLE_FILTER_EN
    localparam logic [3:0] FiltLast = 4'(FILTER_LEN - 1);

    for (genvar ch = 0; ch < 2; ch++) begin : gen_filt
        logic [3:0] cnt_q;
        logic       filt_q;

        // Output flips on the FILTER_LEN-th consecutive differing sample.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q  <= 4'd0;
                filt_q <= 1'b0;
            end else if (sync2_q[ch] == filt_q) begin
                cnt_q <= 4'd0;
            end else if (cnt_q == FiltLast) begin
                cnt_q  <= 4'd0;
                filt_q <= sync2_q[ch];
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end

        assign cond[ch] = filt_q;
    end
`else
    assign cond = sync2_q;
`endif

    logic [1:0]           cur_q, prev_q;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic [POS_WIDTH-1:0] pos_frame_q;
    logic [7:0]           acc_q, acc_d;
    logic [7:0]           delta_q;
    logic                 step_q, dir_q, dir_d, err_q;
    logic [1:0]           diff;
    logic                 valid_step, two_change, step_inc;

    always_comb begin
        diff       = cur_q ^ prev_q;
        valid_step = (diff == 2'b01) || (diff == 2'b10);
        two_change = (diff == 2'b11);
        // Forward order 00->01->11->10: new B differs from old A.
        step_inc   = prev_q[1] ^ cur_q[0];
        pos_d      = pos_q;
        acc_d      = acc_q;
        dir_d      = dir_q;
        if (valid_step) begin
            dir_d = step_inc;
            if (step_inc) begin
                if (pos_q != PosMax) pos_d = pos_q + 1'b1;
                if (acc_q != AccMax) acc_d = acc_q + 8'd1;
            end else begin
                if (pos_q != '0) pos_d = pos_q - 1'b1;
                if (acc_q != AccMin) acc_d = acc_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q       <= 2'b00;
            prev_q      <= 2'b00;
            pos_q       <= '0;
            pos_frame_q <= '0;
            acc_q       <= 8'd0;
            delta_q     <= 8'd0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cur_q  <= cond;
            prev_q <= cur_q;
            pos_q  <= pos_d;
            step_q <= valid_step;
            dir_q  <= dir_d;
            err_q  <= two_change;
            if (frame_latch) begin
                pos_frame_q <= pos_d;
                delta_q     <= acc_d;
                acc_q       <= 8'd0;
            end else begin
                acc_q <= acc_d;
            end
        end
    end

    assign position       = pos_q;
    assign position_frame = pos_frame_q;
    assign delta_frame    = delta_q;
    assign step           = step_q;
    assign dir            = dir_q;
    assign quad_err       = err_q;

endmodule

// File: tb/tb_quad_paddle_decoder.sv
// Directed bench for quad_paddle_decoder; filter scenario runs only when
// QUAD_PADDLE_FILTER_EN is defined.
module tb_quad_paddle_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       quadA = 1'b0;
    logic       quadB = 1'b0;
    logic       frame_latch = 1'b0;
    logic [8:0] position, position_frame;
    logic [7:0] delta_frame;
    logic       step, dir, quad_err;

    int n_cmp = 0;
    int n_bad = 0;
    int idx = 0;
    int step_total = 0;
    int err_total = 0;

    quad_paddle_decoder dut (
        .clk(clk),
        .reset(reset),
        .quadA(quadA),
        .quadB(quadB),
        .frame_latch(frame_latch),
        .position(position),
        .position_frame(position_frame),
        .delta_frame(delta_frame),
        .step(step),
        .dir(dir),
        .quad_err(quad_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step) step_total <= step_total + 1;
        if (quad_err) err_total <= err_total + 1;
    end

    function automatic logic [1:0] gray(input int i);
        case (i & 3)
            0: gray = 2'b00;
            1: gray = 2'b01;
            2: gray = 2'b11;
            default: gray = 2'b10;
        endcase
    endfunction

    // All tasks start and end at a negedge.
    task automatic drive_idx(input int i);
        logic [1:0] c;
        idx = i & 3;
        c = gray(idx);
        quadA = c[1];
        quadB = c[0];
    endtask

    task automatic do_inc(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            drive_idx(idx + 1);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic do_dec(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            drive_idx(idx + 3);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        drive_idx(0);
        frame_latch = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_latch = 1'b1;
        @(negedge clk);
        frame_latch = 1'b0;
    endtask

    task automatic test_reset();
        int s0;
        apply_reset();
        n_cmp++;
        if ({position, position_frame, delta_frame, step, dir, quad_err} !== 29'd0) begin
            n_bad++;
            $display("FAIL reset_state: got pos=%0d pf=%0d df=%0d st=%b dir=%b err=%b expected all 0",
                     position, position_frame, delta_frame, step, dir, quad_err);
        end
        s0 = step_total + err_total;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (step_total + err_total !== s0 || position !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_quiet: got pulses=%0d pos=%0d expected 0 pulses pos=0",
                     step_total + err_total - s0, position);
        end
    endtask

    task automatic test_latency();
        apply_reset();
        drive_idx(1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (step !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: got step=%b expected 0 after 3 edges", step);
        end
        @(negedge clk);
        n_cmp++;
        if (step !== 1'b1 || dir !== 1'b1 || position !== 9'd1) begin
            n_bad++;
            $display("FAIL latency_step: got step=%b dir=%b pos=%0d expected 1 1 1",
                     step, dir, position);
        end
        @(negedge clk);
        n_cmp++;
        if (step !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_pulse_width: got step=%b expected 0", step);
        end
    endtask

    task automatic test_increment();
        int s0, e0;
        apply_reset();
        s0 = step_total;
        e0 = err_total;
        do_inc(10, 20);
        n_cmp++;
        if (position !== 9'd10 || dir !== 1'b1) begin
            n_bad++;
            $display("FAIL inc_position: got pos=%0d dir=%b expected 10 1", position, dir);
        end
        n_cmp++;
        if (step_total - s0 !== 10 || err_total - e0 !== 0) begin
            n_bad++;
            $display("FAIL inc_pulses: got steps=%0d errs=%0d expected 10 0",
                     step_total - s0, err_total - e0);
        end
        frame_pulse();
        n_cmp++;
        if (position_frame !== 9'd10 || delta_frame !== 8'd10) begin
            n_bad++;
            $display("FAIL inc_frame: got pf=%0d df=%0d expected 10 10",
                     position_frame, delta_frame);
        end
    endtask

    task automatic test_decrement_floor();
        int s0;
        apply_reset();
        s0 = step_total;
        do_dec(3, 8);
        n_cmp++;
        if (position !== 9'd0 || dir !== 1'b0 || step_total - s0 !== 3) begin
            n_bad++;
            $display("FAIL dec_floor: got pos=%0d dir=%b steps=%0d expected 0 0 3",
                     position, dir, step_total - s0);
        end
        frame_pulse();
        n_cmp++;
        if (delta_frame !== 8'hFD || position_frame !== 9'd0) begin
            n_bad++;
            $display("FAIL dec_delta: got df=%h pf=%0d expected fd 0", delta_frame, position_frame);
        end
    endtask

    task automatic test_saturation();
        int s0;
        apply_reset();
        do_inc(511, 3);
        repeat (5) @(negedge clk);
        frame_pulse();
        n_cmp++;
        if (position !== 9'd511 || delta_frame !== 8'h7F) begin
            n_bad++;
            $display("FAIL sat_fill: got pos=%0d df=%h expected 511 7f", position, delta_frame);
        end
        s0 = step_total;
        do_inc(2, 8);
        n_cmp++;
        if (position !== 9'd511 || step_total - s0 !== 2) begin
            n_bad++;
            $display("FAIL sat_ceiling: got pos=%0d steps=%0d expected 511 2",
                     position, step_total - s0);
        end
        frame_pulse();
        n_cmp++;
        if (delta_frame !== 8'd2 || position_frame !== 9'd511) begin
            n_bad++;
            $display("FAIL sat_delta: got df=%0d pf=%0d expected 2 511", delta_frame, position_frame);
        end
    endtask

    task automatic test_quad_err();
        int s0, e0;
        apply_reset();
        do_inc(5, 6);
        do_dec(1, 6);
        s0 = step_total;
        e0 = err_total;
        quadA = 1'b1;
        quadB = 1'b1;
        idx = 2;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (err_total - e0 !== 1 || step_total - s0 !== 0) begin
            n_bad++;
            $display("FAIL qerr_pulse: got errs=%0d steps=%0d expected 1 0",
                     err_total - e0, step_total - s0);
        end
        n_cmp++;
        if (position !== 9'd4 || dir !== 1'b0) begin
            n_bad++;
            $display("FAIL qerr_hold: got pos=%0d dir=%b expected 4 0", position, dir);
        end
        do_inc(1, 6);
        n_cmp++;
        if (position !== 9'd5 || dir !== 1'b1) begin
            n_bad++;
            $display("FAIL qerr_resync: got pos=%0d dir=%b expected 5 1", position, dir);
        end
    endtask

    task automatic test_frame_coincident();
        apply_reset();
        do_inc(5, 6);
        frame_pulse();
        n_cmp++;
        if (delta_frame !== 8'd5) begin
            n_bad++;
            $display("FAIL coin_pre: got df=%0d expected 5", delta_frame);
        end
        drive_idx(idx + 1);
        repeat (3) @(negedge clk);
        frame_pulse();
        n_cmp++;
        if (position_frame !== 9'd6 || delta_frame !== 8'd1 || position !== 9'd6) begin
            n_bad++;
            $display("FAIL coin_snap: got pf=%0d df=%0d pos=%0d expected 6 1 6",
                     position_frame, delta_frame, position);
        end
        frame_pulse();
        n_cmp++;
        if (delta_frame !== 8'd0 || position_frame !== 9'd6) begin
            n_bad++;
            $display("FAIL coin_cleared: got df=%0d pf=%0d expected 0 6", delta_frame, position_frame);
        end
    endtask

    task automatic test_back_to_back();
        drive_idx(idx + 1);
        repeat (3) @(negedge clk);
        frame_latch = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (delta_frame !== 8'd1 || position_frame !== 9'd7) begin
            n_bad++;
            $display("FAIL b2b_first: got df=%0d pf=%0d expected 1 7", delta_frame, position_frame);
        end
        @(negedge clk);
        frame_latch = 1'b0;
        n_cmp++;
        if (delta_frame !== 8'd0 || position_frame !== 9'd7) begin
            n_bad++;
            $display("FAIL b2b_second: got df=%0d pf=%0d expected 0 7", delta_frame, position_frame);
        end
        do_inc(1, 6);
        n_cmp++;
        if (position !== 9'd8 || position_frame !== 9'd7 || delta_frame !== 8'd0) begin
            n_bad++;
            $display("FAIL frame_hold: got pos=%0d pf=%0d df=%0d expected 8 7 0",
                     position, position_frame, delta_frame);
        end
    endtask

    task automatic test_reset_priority();
        int s0;
        apply_reset();
        do_inc(3, 6);
        s0 = step_total;
        drive_idx(idx + 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        frame_latch = 1'b1;
        @(negedge clk);
        drive_idx(0);
        @(negedge clk);
        reset = 1'b0;
        frame_latch = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (position !== 9'd0 || position_frame !== 9'd0 || delta_frame !== 8'd0 ||
            step_total !== s0) begin
            n_bad++;
            $display("FAIL reset_priority: got pos=%0d pf=%0d df=%0d steps=%0d expected 0 0 0 0",
                     position, position_frame, delta_frame, step_total - s0);
        end
    endtask

`ifdef QUAD_PADDLE_FILTER_EN
    task automatic test_filter();
        int s0;
        apply_reset();
        s0 = step_total;
        quadA = 1'b1;
        repeat (2) @(negedge clk);
        quadA = 1'b0;
        repeat (15) @(negedge clk);
        n_cmp++;
        if (step_total !== s0 || position !== 9'd0) begin
            n_bad++;
            $display("FAIL filt_glitch: got steps=%0d pos=%0d expected 0 0",
                     step_total - s0, position);
        end
        drive_idx(1);
        repeat (7) @(negedge clk);
        n_cmp++;
        if (step !== 1'b0) begin
            n_bad++;
            $display("FAIL filt_early: got step=%b expected 0 after 7 edges... wait", step);
        end
        @(negedge clk);
        n_cmp++;
        if (step !== 1'b1 || position !== 9'd1) begin
            n_bad++;
            $display("FAIL filt_latency: got step=%b pos=%0d expected 1 1", step, position);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_increment();
        test_decrement_floor();
        test_saturation();
        test_quad_err();
        test_frame_coincident();
        test_back_to_back();
        test_reset_priority();
`ifdef QUAD_PADDLE_FILTER_EN
        test_filter();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quad_paddle_decoder.md
QUAD_PADDLE_DECODER -- requirements
Module: quad_paddle_decoder

Interface
REQ-001 SHALL have parameter POS_WIDTH, default 9, paddle position width in bits.
REQ-002 SHALL have parameter POS_MAX, default 511, upper saturation limit of position; must be at most 2^POS_WIDTH-1.
REQ-003 SHALL have parameter FILTER_LEN, default 4, number of consecutive stable samples the glitch filter requires; range 2..15.
REQ-004 SHALL have port clk  input  1  system clock; the only clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port quadA  input  1  encoder channel A, asynchronous.
REQ-007 SHALL have port quadB  input  1  encoder channel B, asynchronous.
REQ-008 SHALL have port frame_latch  input  1  single-cycle snapshot strobe, e.g. once per video frame.
REQ-009 SHALL have port position  output  POS_WIDTH  live saturating paddle position.
REQ-010 SHALL have port position_frame  output  POS_WIDTH  position captured at the last frame_latch.
REQ-011 SHALL have port delta_frame  output  8  signed step count between the last two frame_latch strobes.
REQ-012 SHALL have port step  output  1  one-cycle pulse on each valid quadrature transition.
REQ-013 SHALL have port dir  output  1  direction of the last valid step; 1 = increment.
REQ-014 SHALL have port quad_err  output  1  one-cycle pulse when both channels change in the same decode cycle.

Function
REQ-015 SHALL pass each channel through its own 2-flop synchronizer before any other logic uses it.
REQ-016 SHALL hold a decoder state register (prev A,B) and compare it each cycle against the current conditioned A,B.
REQ-017 SHALL treat 00->01->11->10->00 as increment steps (dir=1) and the reverse sequence as decrement steps (dir=0).
REQ-018 SHALL register step, dir and quad_err; with the filter compiled out, a clean input edge produces the step pulse 3 clk edges after the edge that first samples it.
REQ-019 SHALL, on a two-bit change, pulse quad_err, leave position, dir and step unchanged, and load prev with the new A,B.
REQ-020 SHALL increment position on an increment step unless position==POS_MAX, and decrement on a decrement step unless position==0; a blocked step still pulses step.
REQ-021 SHALL keep an internal signed 8-bit accumulator of valid steps, including blocked ones, saturating at +127 and -128.
REQ-022 SHALL, on frame_latch, load position_frame with the position value that includes any same-cycle step.
REQ-023 SHALL, on frame_latch, load delta_frame with the accumulator value that includes any same-cycle step, and clear the accumulator to 0.
REQ-024 SHALL update position_frame and delta_frame only on frame_latch, holding them otherwise.
REQ-025 SHALL treat back-to-back frame_latch cycles as independent snapshots; a second consecutive strobe yields delta_frame equal to the steps seen in that cycle only.

Reset
REQ-026 SHALL, while reset is high at a clk edge, set position, position_frame, delta_frame, the accumulator, step, dir and quad_err to 0, clear the filter counters, and set the synchronizers, filter outputs and prev to 00.
REQ-027 SHALL give reset priority over steps and frame_latch in the same cycle; steps in progress are discarded.
REQ-028 SHALL NOT generate a step or quad_err in the first cycle after reset if the inputs are at 00.

Configuration
REQ-029 SHALL compile the per-channel glitch filter only when macro QUAD_PADDLE_FILTER_EN is defined.
REQ-030 SHALL, with QUAD_PADDLE_FILTER_EN defined, update a channel's filtered value only after FILTER_LEN consecutive synchronized samples differ from it; any matching sample clears that channel's counter.
REQ-031 SHALL, with the filter defined, add exactly FILTER_LEN cycles to the REQ-018 latency.
REQ-032 SHALL, without QUAD_PADDLE_FILTER_EN, feed the synchronizer outputs directly to the decoder, leaving FILTER_LEN unused.

Verification
REQ-033 SHALL cover: 10 clean increment steps from reset, 20 cycles apart -> position=10, 10 step pulses, dir=1, no quad_err.
REQ-034 SHALL cover: 3 decrement steps from position 0 -> position stays 0, 3 step pulses with dir=0, and an accumulator of -3 at the next frame_latch.
REQ-035 SHALL cover: position driven to 511, then 2 increment steps -> position=511 and delta_frame=+2 at the next frame_latch.
REQ-036 SHALL cover: A and B toggled simultaneously from 00 to 11 -> one quad_err pulse, and position and dir unchanged.
REQ-037 SHALL cover, with the filter defined and FILTER_LEN=4: a 2-cycle glitch on A -> no step; a 4-cycle-stable change -> one step at latency 7.
REQ-038 SHALL cover: frame_latch coincident with an increment step at position 5 -> position_frame=6, delta_frame includes the step, and the accumulator is 0 afterwards.
